// File: rtl/logic_gate_pipe_if.sv
// Handshake bundle for logic_gate_pipe: input side (a, b, op) and output side (c, any).
// Modports: master drives operands and out_ready; slave is the pipeline itself.
interface logic_gate_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_c;
    logic             out_any;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_c, out_any
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_c, out_any
    );
endinterface

// File: rtl/logic_gate_pipe.sv
// Bitwise 2-operand logic op (OR/AND/XOR/NOR/NAND/XNOR/A/~A) behind a STAGES-deep elastic pipe.
// Ports: clk, rst_n (async low), bus (slave modport), stat_count when LOGIC_GATE_STATS_EN is defined.
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    logic_gate_pipe_if.slave  bus
`ifdef LOGIC_GATE_STATS_EN
    ,
    output logic [15:0]       stat_count
`endif
);
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] any_q;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  op_res;
    logic              accept;

    always_comb begin
        op_res = '0;
        unique case (bus.in_op)
            3'd0: op_res = bus.in_a | bus.in_b;
            3'd1: op_res = bus.in_a & bus.in_b;
            3'd2: op_res = bus.in_a ^ bus.in_b;
            3'd3: op_res = ~(bus.in_a | bus.in_b);
            3'd4: op_res = ~(bus.in_a & bus.in_b);
            3'd5: op_res = ~(bus.in_a ^ bus.in_b);
            3'd6: op_res = bus.in_a;
            3'd7: op_res = ~bus.in_a;
        endcase
    end

    // Advance chain is evaluated from the output back so ready ripples
    // combinationally through a full pipe in one cycle.
    always_comb begin
        adv = '0;
        adv[LAST] = valid_q[LAST] & bus.out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
        end
    end

    assign bus.in_ready = ~valid_q[0] | adv[0];
    assign accept       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q[0] <= 1'b0;
            any_q[0]   <= 1'b0;
            data_q[0]  <= '0;
        end else if (accept) begin
            valid_q[0] <= 1'b1;
            any_q[0]   <= |op_res;
            data_q[0]  <= op_res;
        end else if (adv[0]) begin
            valid_q[0] <= 1'b0;
        end
    end

    for (genvar g = 1; g < STAGES; g++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q[g] <= 1'b0;
                any_q[g]   <= 1'b0;
                data_q[g]  <= '0;
            end else if (adv[g-1]) begin
                valid_q[g] <= 1'b1;
                any_q[g]   <= any_q[g-1];
                data_q[g]  <= data_q[g-1];
            end else if (adv[g]) begin
                valid_q[g] <= 1'b0;
            end
        end
    end

    // Payload of the last stage only changes on a load, so out_c keeps
    // the last delivered word while the pipe is empty.
    assign bus.out_valid = valid_q[LAST];
    assign bus.out_c     = data_q[LAST];
    assign bus.out_any   = any_q[LAST];

`ifdef LOGIC_GATE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count <= '0;
        end else if (accept && stat_count != 16'hFFFF) begin
            stat_count <= stat_count + 16'd1;
        end
    end
`endif
endmodule
